// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory arbiter and its instruction fetch buffer.
// Contents:
//   state_e          arbiter FSM encoding (IDLE, DREQ, IREQ, RESP)
//   DRW_READ/WRITE   encodings of the CPU data-request field
//   ibuf_*_w()       index/select/tag widths derived from the buffer depth
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DREQ = 2'd1,
    IREQ = 2'd2,
    RESP = 2'd3
  } state_e;

  localparam logic [1:0] DRW_READ  = 2'b10;
  localparam logic [1:0] DRW_WRITE = 2'b01;

  // Number of address bits used as the buffer index (0 for a single entry).
  function automatic int ibuf_idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 0;
  endfunction

  // Width of the index signal itself; never zero so it can always be declared.
  function automatic int ibuf_sel_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Tag covers every address bit above the word offset and the index.
  function automatic int ibuf_tag_w(input int addr_w, input int depth);
    return addr_w - 2 - ibuf_idx_w(depth);
  endfunction

endpackage

// File: rtl/cpu_ibuf.sv
// Direct-mapped instruction fetch buffer.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset (clears valid bits)
//   lookup_addr_i -> hit_o,      combinational lookup; rdata_o is zero on a miss
//                    rdata_o
//   fill_en_i, fill_addr_i,      write one word and mark its entry valid
//   fill_data_i
//   inv_en_i, inv_addr_i         drop the entry holding inv_addr_i, if it is present
module cpu_ibuf
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_addr_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] rdata_o,
  input  logic              fill_en_i,
  input  logic [ADDR_W-1:0] fill_addr_i,
  input  logic [DATA_W-1:0] fill_data_i,
  input  logic              inv_en_i,
  input  logic [ADDR_W-1:0] inv_addr_i
);

  localparam int IDX_W = ibuf_idx_w(DEPTH);
  localparam int SEL_W = ibuf_sel_w(DEPTH);
  localparam int TAG_W = ibuf_tag_w(ADDR_W, DEPTH);

  function automatic logic [SEL_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
    return SEL_W'((a >> 2) & ADDR_W'(DEPTH - 1));
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] a);
    return TAG_W'(a >> (2 + IDX_W));
  endfunction

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [TAG_W-1:0]  tag_q  [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [SEL_W-1:0]  lidx, fidx, iidx;
  logic              inv_hit;

  assign lidx    = idx_of(lookup_addr_i);
  assign fidx    = idx_of(fill_addr_i);
  assign iidx    = idx_of(inv_addr_i);

  assign hit_o   = valid_q[lidx] && (tag_q[lidx] == tag_of(lookup_addr_i));
  // Gated so a miss (including the reset state) never exposes stale storage.
  assign rdata_o = hit_o ? data_q[lidx] : '0;
  assign inv_hit = valid_q[iidx] && (tag_q[iidx] == tag_of(inv_addr_i));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (fill_en_i) begin
      valid_q[fidx] <= 1'b1;
    end else if (inv_en_i && inv_hit) begin
      valid_q[iidx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en_i) begin
      data_q[fidx] <= fill_data_i;
      tag_q[fidx]  <= tag_of(fill_addr_i);
    end
  end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Merges the CPU instruction-fetch and data ports onto one variable-latency bus.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   iaddr -> iin             fetch address / instruction returned
//   daddr, dout, drw -> din  data address, store data, request (10 rd, 01 wr) / load data
//   cpu_stall                freezes the CPU until all accesses of the cycle are done
//   bus_req, bus_we,         bus request, write enable, address, write data
//   bus_addr, bus_wdata
//   bus_rdata, bus_ack       bus read data, one-cycle completion pulse
//   bus_err, err_clr         sticky timeout flag and its clear
module cpu_mem_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IBUF_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iin,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dout,
  input  logic [1:0]        drw,
  output logic [DATA_W-1:0] din,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err,
  input  logic              err_clr
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              TO_EN    = (TIMEOUT > 0);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] iaddr_q, iaddr_d, daddr_q, daddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d, need_i_q, need_i_d, gap_q, gap_d, err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] load_q, load_d, din_q, din_d, iin_q, iin_d;

  logic              ibuf_hit;
  logic [DATA_W-1:0] ibuf_rdata;
  logic              need_d, need_i, go, acked, expire, done;

  assign need_d = (drw == DRW_READ) || (drw == DRW_WRITE);
  assign need_i = !ibuf_hit;
  assign go     = need_d || need_i;

  // gap_q marks the idle bus cycle inserted between the data and the fetch
  // transaction; ack and the timeout are both ignored during it.
  assign acked  = bus_ack && !gap_q;
  assign expire = TO_EN && !gap_q && !bus_ack && (cnt_q == CNT_LAST);
  assign done   = acked || expire;

  cpu_ibuf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (IBUF_DEPTH)
  ) u_ibuf (
    .clk           (clk),
    .rst           (rst),
    .lookup_addr_i (iaddr),
    .hit_o         (ibuf_hit),
    .rdata_o       (ibuf_rdata),
    .fill_en_i     ((state_q == IREQ) && acked),
    .fill_addr_i   (iaddr_q),
    .fill_data_i   (bus_rdata),
    .inv_en_i      ((state_q == DREQ) && we_q && done),
    .inv_addr_i    (daddr_q)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d  = state_q;
    iaddr_d  = iaddr_q;
    daddr_d  = daddr_q;
    wdata_d  = wdata_q;
    we_d     = we_q;
    need_i_d = need_i_q;
    gap_d    = 1'b0;
    cnt_d    = cnt_q;
    load_d   = load_q;
    din_d    = din_q;
    iin_d    = iin_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          iaddr_d  = iaddr;
          daddr_d  = daddr;
          wdata_d  = dout;
          we_d     = (drw == DRW_WRITE);
          need_i_d = need_i;
          // On a hit this is the instruction handed back in RESP.
          iin_d    = ibuf_rdata;
          cnt_d    = '0;
          state_d  = need_d ? DREQ : IREQ;
        end
      end
      DREQ: begin
        if (done) begin
          cnt_d = '0;
          if (!we_q) load_d = acked ? bus_rdata : '0;
          if (need_i_q) begin
            state_d = IREQ;
            gap_d   = 1'b1;
          end else begin
            state_d = RESP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IREQ: begin
        if (done) begin
          cnt_d   = '0;
          iin_d   = acked ? bus_rdata : '0;
          state_d = RESP;
        end else if (!gap_q) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        din_d   = load_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A timeout in the same cycle as err_clr keeps the flag set.
    if (expire && ((state_q == DREQ) || (state_q == IREQ))) err_d = 1'b1;
    else if (err_clr)                                        err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      need_i_q <= 1'b0;
      gap_q    <= 1'b0;
      cnt_q    <= '0;
      load_q   <= '0;
      din_q    <= '0;
      iin_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      we_q     <= we_d;
      need_i_q <= need_i_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      din_q    <= din_d;
      iin_q    <= iin_d;
      err_q    <= err_d;
    end
  end

  // Captured request fields are only observed outside IDLE, so no reset.
  always_ff @(posedge clk) begin
    iaddr_q <= iaddr_d;
    daddr_q <= daddr_d;
    wdata_q <= wdata_d;
  end

  // Outputs; bus_* derive from the state so an asynchronous reset drops them at once.
  always_comb begin
    cpu_stall = 1'b0;
    bus_req   = 1'b0;
    bus_we    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
    iin       = iin_q;
    din       = din_q;
    case (state_q)
      IDLE: begin
        cpu_stall = go && !rst;
        if (!go) iin = ibuf_rdata;
      end
      DREQ: begin
        cpu_stall = 1'b1;
        bus_req   = 1'b1;
        bus_we    = we_q;
        bus_addr  = daddr_q;
        bus_wdata = we_q ? wdata_q : '0;
      end
      IREQ: begin
        cpu_stall = 1'b1;
        bus_req   = !gap_q;
        bus_addr  = iaddr_q;
      end
      RESP: begin
        din = load_q;
      end
      default: ;
    endcase
  end

  assign bus_err = err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] iaddr, daddr, dout, bus_rdata;
  logic [1:0]  drw;
  logic        bus_ack, err_clr;
  logic [31:0] iin, din, bus_addr, bus_wdata;
  logic        cpu_stall, bus_req, bus_we, bus_err;

  always #5 clk = ~clk;

  cpu_mem_arbiter #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .IBUF_DEPTH (8),
    .TIMEOUT    (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .iaddr     (iaddr),
    .iin       (iin),
    .daddr     (daddr),
    .dout      (dout),
    .drw       (drw),
    .din       (din),
    .cpu_stall (cpu_stall),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .bus_err   (bus_err),
    .err_clr   (err_clr)
  );

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  txn_t        exp_q[$];
  txn_t        obs_q[$];
  int          obs_w[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] bmem [logic [31:0]];
  int          lat    = 0;
  bit          ack_en = 1'b1;

  // Bus slave: acks after the request has been held for 'lat' cycles.
  initial begin
    int rc;
    rc = 0;
    bus_ack = 1'b0;
    bus_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      bus_ack = 1'b0;
      bus_rdata = '0;
      if (bus_req && ack_en) begin
        if (rc >= lat) begin
          bus_ack = 1'b1;
          bus_rdata = bmem.exists(bus_addr) ? bmem[bus_addr] : 32'h0;
          if (bus_we) bmem[bus_addr] = bus_wdata;
          rc = 0;
        end else begin
          rc++;
        end
      end else begin
        rc = 0;
      end
    end
  end

  // Records every bus_req pulse (start fields and width in cycles).
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req) begin
        if (!prev) begin
          obs_q.push_back('{we: bus_we, addr: bus_addr, wdata: bus_wdata});
          obs_w.push_back(1);
        end else begin
          obs_w[obs_w.size()-1]++;
        end
      end
      prev = bus_req;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Called at posedge+1; returns at posedge+1 after the CPU has advanced.
  task automatic do_access(input logic [31:0] ia, input logic [1:0] rw,
                           input logic [31:0] da, input logic [31:0] wd,
                           output int nstall, output logic [31:0] iin_v,
                           output logic [31:0] din_v, output logic err_v);
    bit fin;
    nstall = 0;
    fin = 1'b0;
    iaddr = ia;
    drw = rw;
    daddr = da;
    dout = wd;
    while (!fin) begin
      @(negedge clk);
      if (!cpu_stall) begin
        fin = 1'b1;
      end else begin
        nstall++;
        if (nstall > 40) begin
          checks++;
          failures++;
          $display("FAIL access_bound: cpu_stall=%0b after %0d cycles, required 0", cpu_stall, nstall);
          fin = 1'b1;
        end else begin
          @(posedge clk);
          #1;
        end
      end
    end
    iin_v = iin;
    din_v = din;
    err_v = bus_err;
    @(posedge clk);
    #1;
    drw = 2'b00;
  endtask

  task automatic test_reset();
    iaddr = '0; daddr = '0; dout = '0; drw = 2'b00; err_clr = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL rst_stall: got %0b required 0", cpu_stall); end
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL rst_req: got %0b required 0", bus_req); end
    checks++; if ({bus_we, bus_addr, bus_wdata} !== 65'h0) begin failures++; $display("FAIL rst_bus: we=%0b addr=%h wdata=%h required all 0", bus_we, bus_addr, bus_wdata); end
    checks++; if (iin !== 32'h0) begin failures++; $display("FAIL rst_iin: got %h required 0", iin); end
    checks++; if (din !== 32'h0) begin failures++; $display("FAIL rst_din: got %h required 0", din); end
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL rst_err: got %0b required 0", bus_err); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_fetch_miss_hit();
    int n; logic [31:0] iv, dv; logic ev; txn_t e, o;
    bmem[32'h0] = 32'h8C010004;
    lat = 2;
    exp_q.push_back('{we: 1'b0, addr: 32'h0, wdata: 32'h0});
    do_access(32'h0, 2'b00, 32'h0, 32'h0, n, iv, dv, ev);
    checks++; if (n !== 4) begin failures++; $display("FAIL miss_stall: got %0d cycles required 4", n); end
    checks++; if (iv !== 32'h8C010004) begin failures++; $display("FAIL miss_iin: got %h required 8c010004", iv); end
    checks++; if (obs_q.size() !== 1) begin failures++; $display("FAIL miss_pulses: got %0d required 1", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL miss_txn: no request, required addr=%h", e.addr); end
      else begin
        o = obs_q.pop_front(); void'(obs_w.pop_front());
        if (o !== e) begin failures++; $display("FAIL miss_txn: got we=%0b addr=%h wd=%h required we=%0b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
    obs_q.delete(); obs_w.delete();
    do_access(32'h0, 2'b00, 32'h0, 32'h0, n, iv, dv, ev);
    checks++; if (n !== 0) begin failures++; $display("FAIL hit_stall: got %0d cycles required 0", n); end
    checks++; if (iv !== 32'h8C010004) begin failures++; $display("FAIL hit_iin: got %h required 8c010004", iv); end
    checks++; if (obs_q.size() !== 0) begin failures++; $display("FAIL hit_noreq: got %0d bus requests required 0", obs_q.size()); end
    obs_q.delete(); obs_w.delete();
  endtask

  task automatic test_load_then_fetch();
    int n; logic [31:0] iv, dv; logic ev; txn_t e, o;
    bmem[32'h100] = 32'h12345678;
    bmem[32'h4]   = 32'h8C020008;
    lat = 1;
    exp_q.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_q.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0});
    do_access(32'h4, 2'b10, 32'h100, 32'h0, n, iv, dv, ev);
    checks++; if (n !== 6) begin failures++; $display("FAIL load_stall: got %0d cycles required 6", n); end
    checks++; if (dv !== 32'h12345678) begin failures++; $display("FAIL load_din: got %h required 12345678", dv); end
    checks++; if (iv !== 32'h8C020008) begin failures++; $display("FAIL load_iin: got %h required 8c020008", iv); end
    checks++; if (obs_q.size() !== 2) begin failures++; $display("FAIL load_pulses: got %0d required 2", obs_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL load_txn: no request, required addr=%h", e.addr); end
      else begin
        o = obs_q.pop_front(); void'(obs_w.pop_front());
        if (o !== e) begin failures++; $display("FAIL load_txn: got we=%0b addr=%h wd=%h required we=%0b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
    obs_q.delete(); obs_w.delete();
  endtask

  task automatic test_store_coherence();
    int n; logic [31:0] iv, dv; logic ev; txn_t e, o;
    lat = 0;
    exp_q.push_back('{we: 1'b1, addr: 32'h4, wdata: 32'hDEADBEEF});
    do_access(32'h4, 2'b01, 32'h4, 32'hDEADBEEF, n, iv, dv, ev);
    checks++; if (n !== 2) begin failures++; $display("FAIL store_stall: got %0d cycles required 2", n); end
    checks++; if (iv !== 32'h8C020008) begin failures++; $display("FAIL store_iin: got %h required 8c020008", iv); end
    exp_q.push_back('{we: 1'b0, addr: 32'h4, wdata: 32'h0});
    do_access(32'h4, 2'b00, 32'h0, 32'h0, n, iv, dv, ev);
    checks++; if (n !== 2) begin failures++; $display("FAIL refetch_stall: got %0d cycles required 2", n); end
    checks++; if (iv !== 32'hDEADBEEF) begin failures++; $display("FAIL refetch_iin: got %h required deadbeef", iv); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL store_txn: no request, required addr=%h", e.addr); end
      else begin
        o = obs_q.pop_front(); void'(obs_w.pop_front());
        if (o !== e) begin failures++; $display("FAIL store_txn: got we=%0b addr=%h wd=%h required we=%0b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
    obs_q.delete(); obs_w.delete();
  endtask

  task automatic test_timeout_and_clear();
    int n; logic [31:0] iv, dv; logic ev; txn_t e, o;
    ack_en = 1'b0;
    exp_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    do_access(32'h40, 2'b00, 32'h0, 32'h0, n, iv, dv, ev);
    checks++; if (n !== 5) begin failures++; $display("FAIL to_stall: got %0d cycles required 5", n); end
    checks++; if (iv !== 32'h0) begin failures++; $display("FAIL to_iin: got %h required 0", iv); end
    checks++; if (ev !== 1'b1) begin failures++; $display("FAIL to_err: got %0b required 1", ev); end
    checks++; if (obs_w.size() == 0 || obs_w[0] !== 4) begin failures++; $display("FAIL to_width: got %0d cycles (%0d pulses) required 4", (obs_w.size() > 0) ? obs_w[0] : 0, obs_w.size()); end
    ack_en = 1'b1;
    lat = 0;
    err_clr = 1'b1;
    do_access(32'h0, 2'b00, 32'h0, 32'h0, n, iv, dv, ev);
    err_clr = 1'b0;
    checks++; if (ev !== 1'b1) begin failures++; $display("FAIL err_sticky: got %0b required 1 before clear edge", ev); end
    @(negedge clk);
    checks++; if (bus_err !== 1'b0) begin failures++; $display("FAIL err_clr: got %0b required 0", bus_err); end
    @(posedge clk);
    #1;
    bmem[32'h40] = 32'h00A00040;
    exp_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    do_access(32'h40, 2'b00, 32'h0, 32'h0, n, iv, dv, ev);
    checks++; if (n !== 2) begin failures++; $display("FAIL nofill_stall: got %0d cycles required 2", n); end
    checks++; if (iv !== 32'h00A00040) begin failures++; $display("FAIL nofill_iin: got %h required 00a00040", iv); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL to_txn: no request, required addr=%h", e.addr); end
      else begin
        o = obs_q.pop_front(); void'(obs_w.pop_front());
        if (o !== e) begin failures++; $display("FAIL to_txn: got we=%0b addr=%h wd=%h required we=%0b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
    obs_q.delete(); obs_w.delete();
  endtask

  task automatic test_ack_at_timeout();
    int n; logic [31:0] iv, dv; logic ev;
    bmem[32'h80] = 32'h0BADF00D;
    lat = 3;
    do_access(32'h80, 2'b00, 32'h0, 32'h0, n, iv, dv, ev);
    checks++; if (n !== 5) begin failures++; $display("FAIL edge_stall: got %0d cycles required 5", n); end
    checks++; if (iv !== 32'h0BADF00D) begin failures++; $display("FAIL edge_iin: got %h required 0badf00d", iv); end
    checks++; if (ev !== 1'b0) begin failures++; $display("FAIL edge_err: got %0b required 0", ev); end
    checks++; if (obs_q.size() !== 1 || obs_q[0].addr !== 32'h80) begin failures++; $display("FAIL edge_txn: got %0d pulses required one read at 00000080", obs_q.size()); end
    obs_q.delete(); obs_w.delete();
  endtask

  task automatic test_reset_midflight();
    int n; logic [31:0] iv, dv; logic ev; txn_t e, o;
    lat = 0;
    ack_en = 1'b0;
    exp_q.push_back('{we: 1'b0, addr: 32'h200, wdata: 32'h0});
    iaddr = 32'h80; daddr = 32'h200; drw = 2'b10;
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++; if (bus_req !== 1'b0) begin failures++; $display("FAIL arst_req: got %0b required 0", bus_req); end
    checks++; if (bus_addr !== 32'h0) begin failures++; $display("FAIL arst_addr: got %h required 0", bus_addr); end
    checks++; if (cpu_stall !== 1'b0) begin failures++; $display("FAIL arst_stall: got %0b required 0", cpu_stall); end
    @(posedge clk);
    #1;
    drw = 2'b00;
    ack_en = 1'b1;
    rst = 1'b0;
    exp_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0});
    do_access(32'h80, 2'b00, 32'h0, 32'h0, n, iv, dv, ev);
    checks++; if (n !== 2) begin failures++; $display("FAIL arst_miss_stall: got %0d cycles required 2", n); end
    checks++; if (iv !== 32'h0BADF00D) begin failures++; $display("FAIL arst_iin: got %h required 0badf00d", iv); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin failures++; $display("FAIL arst_txn: no request, required addr=%h", e.addr); end
      else begin
        o = obs_q.pop_front(); void'(obs_w.pop_front());
        if (o !== e) begin failures++; $display("FAIL arst_txn: got we=%0b addr=%h wd=%h required we=%0b addr=%h wd=%h", o.we, o.addr, o.wdata, e.we, e.addr, e.wdata); end
      end
    end
    obs_q.delete(); obs_w.delete();
  endtask

  initial begin
    test_reset();
    test_fetch_miss_hit();
    test_load_then_fetch();
    test_store_coherence();
    test_timeout_and_clear();
    test_ack_at_timeout();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
